// File: rtl/f_ifu_pkg.sv
// ---------------------------------------------------------------------------
// f_ifu_pkg
// Shared CPU constants for the fetch unit: reset PC, instruction-memory
// window, the nop encoding, the fetch FSM state type, and the helper that
// decides whether a PC may be fetched.
// ---------------------------------------------------------------------------
package f_ifu_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IM_TOP   = 32'h0000_6FFC;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    // REQ: fetch in progress, HOLD: instruction buffered for the F/D register.
    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_t;

    // A PC is fetchable only when word aligned and inside the instruction
    // memory window (inclusive of IM_TOP, the last word).
    function automatic logic fetch_addr_ok(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr >= IM_BASE) && (addr <= IM_TOP);
    endfunction

endpackage

// File: rtl/f_ifu.sv
// ---------------------------------------------------------------------------
// f_ifu -- instruction fetch unit
// Two-state fetch engine: in REQ it requests the word at F_PC from
// instruction memory (or raises an address error for an unfetchable PC),
// in HOLD it presents the buffered instruction to the F/D register until
// the hazard unit lets it advance to D_npc.
//
// Ports
//   clk           in   sole clock, rising edge
//   reset         in   asynchronous, active-high; clears all state
//   D_npc[31:0]   in   next PC from decode; taken only on advance
//   stall         in   1 = F/D register holds (only meaningful in HOLD)
//   F_imem_req    out  instruction memory read request (level)
//   F_imem_addr   out  read address, always equal to F_PC
//   F_imem_rdata  in   read data, valid with F_imem_valid
//   F_imem_valid  in   one-cycle response strobe
//   F_PC[31:0]    out  PC of the fetched / in-flight instruction
//   F_instr[31:0] out  buffered instruction
//   F_valid       out  F_PC/F_instr consumable by the F/D register
//   F_excAdEL     out  fetch address error on the held instruction
// ---------------------------------------------------------------------------
module f_ifu
    import f_ifu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D_npc,
    input  logic        stall,
    output logic        F_imem_req,
    output logic [31:0] F_imem_addr,
    input  logic [31:0] F_imem_rdata,
    input  logic        F_imem_valid,
    output logic [31:0] F_PC,
    output logic [31:0] F_instr,
    output logic        F_valid,
    output logic        F_excAdEL
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  buffer;
    logic         exc;
    logic         pc_ok;

    assign pc_ok = fetch_addr_ok(pc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_REQ;
            pc     <= PC_RESET;
            buffer <= NOP;
            exc    <= 1'b0;
        end else begin
            case (state)
                ST_REQ: begin
                    // An unfetchable PC never reaches memory; a nop with the
                    // error flag is delivered instead, one cycle later.
                    if (!pc_ok) begin
                        buffer <= NOP;
                        exc    <= 1'b1;
                        state  <= ST_HOLD;
                    end else if (F_imem_valid) begin
                        buffer <= F_imem_rdata;
                        exc    <= 1'b0;
                        state  <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Late memory strobes are ignored here; only the
                    // hazard unit moves the engine on.
                    if (!stall) begin
                        pc    <= D_npc;
                        exc   <= 1'b0;
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

    // The request is gated by reset so that it drops the moment reset
    // rises, abandoning any outstanding fetch.
    assign F_imem_req  = (state == ST_REQ) && pc_ok && !reset;
    assign F_imem_addr = pc;
    assign F_PC        = pc;
    assign F_instr     = buffer;
    assign F_valid     = (state == ST_HOLD);
    assign F_excAdEL   = exc;

endmodule

// File: tb/tb_f_ifu.sv
module tb_f_ifu;

    logic        clk;
    logic        reset;
    logic [31:0] D_npc;
    logic        stall;
    logic        F_imem_req;
    logic [31:0] F_imem_addr;
    logic [31:0] F_imem_rdata;
    logic        F_imem_valid;
    logic [31:0] F_PC;
    logic [31:0] F_instr;
    logic        F_valid;
    logic        F_excAdEL;

    int checks;
    int failures;
    int lat;
    int mcnt;

    f_ifu dut (
        .clk          (clk),
        .reset        (reset),
        .D_npc        (D_npc),
        .stall        (stall),
        .F_imem_req   (F_imem_req),
        .F_imem_addr  (F_imem_addr),
        .F_imem_rdata (F_imem_rdata),
        .F_imem_valid (F_imem_valid),
        .F_PC         (F_PC),
        .F_instr      (F_instr),
        .F_valid      (F_valid),
        .F_excAdEL    (F_excAdEL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: the strobe appears in the lat-th cycle of a
    // continuous request; the word at address A is A ^ 0xA5A5_0000.
    always @(negedge clk) begin
        if (!F_imem_req) begin
            mcnt         = 0;
            F_imem_valid = 1'b0;
            F_imem_rdata = 32'hFFFF_FFFF;
        end else begin
            mcnt         = mcnt + 1;
            F_imem_valid = (mcnt == lat);
            F_imem_rdata = (mcnt == lat) ? (F_imem_addr ^ 32'hA5A5_0000) : 32'hFFFF_FFFF;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        int          lat;
        int          stall_req;
        int          stall_cyc;
        logic [31:0] instr;
        logic        exc;
        int          req_cyc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n;
        checks       = 0;
        failures     = 0;
        mcnt         = 0;
        F_imem_valid = 1'b0;
        F_imem_rdata = 32'hFFFF_FFFF;
        D_npc        = 32'h0;
        stall        = 1'b0;

        //          pc            lat  stq stc instr          exc req_cyc
        vecs[0] = '{32'h0000_3000, 1,  0,  0, 32'hA5A5_3000, 1'b0, 1};
        vecs[1] = '{32'h0000_3004, 1,  0,  0, 32'hA5A5_3004, 1'b0, 1};
        vecs[2] = '{32'h0000_3008, 1,  0,  3, 32'hA5A5_3008, 1'b0, 1};
        vecs[3] = '{32'h0000_3100, 4,  1,  0, 32'hA5A5_3100, 1'b0, 4};
        vecs[4] = '{32'h0000_3002, 1,  0,  0, 32'h0000_0000, 1'b1, 1};
        vecs[5] = '{32'h0000_7000, 1,  0,  1, 32'h0000_0000, 1'b1, 1};
        vecs[6] = '{32'h0000_6FFC, 2,  0,  0, 32'hA5A5_6FFC, 1'b0, 2};
        vecs[7] = '{32'h0000_2FFC, 1,  0,  0, 32'h0000_0000, 1'b1, 1};

        lat   = vecs[0].lat;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc",    F_PC,       32'h0000_3000);
        check("rst_valid", F_valid,    1'b0);
        check("rst_exc",   F_excAdEL,  1'b0);
        check("rst_req",   F_imem_req, 1'b0);
        check("rst_instr", F_instr,    32'h0);

        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            stall = (vecs[i].stall_req != 0);
            n = 0;
            while (!F_valid && n < 20) begin
                check($sformatf("v%0d_req", i), F_imem_req, !vecs[i].exc);
                check($sformatf("v%0d_addr", i), F_imem_addr, vecs[i].pc);
                n = n + 1;
                @(negedge clk);
            end
            check($sformatf("v%0d_req_cycles", i), n, vecs[i].req_cyc);
            check($sformatf("v%0d_pc", i), F_PC, vecs[i].pc);
            check($sformatf("v%0d_instr", i), F_instr, vecs[i].instr);
            check($sformatf("v%0d_exc", i), F_excAdEL, vecs[i].exc);
            check($sformatf("v%0d_hold_req", i), F_imem_req, 1'b0);

            for (int s = 0; s < vecs[i].stall_cyc; s++) begin
                stall = 1'b1;
                D_npc = 32'h0000_5000 + 32'(s * 4);
                @(negedge clk);
                check($sformatf("v%0d_stall_pc", i), F_PC, vecs[i].pc);
                check($sformatf("v%0d_stall_instr", i), F_instr, vecs[i].instr);
                check($sformatf("v%0d_stall_valid", i), F_valid, 1'b1);
                check($sformatf("v%0d_stall_exc", i), F_excAdEL, vecs[i].exc);
            end

            stall = 1'b0;
            if (i < 7) begin
                D_npc = vecs[i + 1].pc;
                lat   = vecs[i + 1].lat;
            end else begin
                D_npc = 32'h0000_3010;
                lat   = 100;
            end
            @(negedge clk);
            check($sformatf("v%0d_adv_valid", i), F_valid, 1'b0);
            check($sformatf("v%0d_adv_exc", i), F_excAdEL, 1'b0);
        end

        // Reset while a fetch at 0x3010 is outstanding.
        check("pre_rst_req",  F_imem_req,  1'b1);
        check("pre_rst_addr", F_imem_addr, 32'h0000_3010);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_req",   F_imem_req, 1'b0);
        check("mid_rst_pc",    F_PC,       32'h0000_3000);
        check("mid_rst_valid", F_valid,    1'b0);
        lat = 1;
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("post_rst_req",  F_imem_req,  1'b1);
        check("post_rst_addr", F_imem_addr, 32'h0000_3000);
        @(negedge clk);
        n = 0;
        while (!F_valid && n < 20) begin
            n = n + 1;
            @(negedge clk);
        end
        check("post_rst_req_cycles", n, 1);
        check("post_rst_instr", F_instr, 32'hA5A5_3000);
        check("post_rst_exc",   F_excAdEL, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/f_ifu.md
F_IFU -- requirements
Module: F_IFU

Interface
REQ-001 SHALL have clk  in  1  sole clock; all state on rising edge.
REQ-002 SHALL have reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have D_npc  in  32  next PC from D-stage NPC logic; sampled only on advance.
REQ-004 SHALL have stall  in  1  hazard-unit stall; 1 = F/D register holds.
REQ-005 SHALL have F_imem_req  out  1  instruction-memory read request, level.
REQ-006 SHALL have F_imem_addr  out  32  read address; equals F_PC.
REQ-007 SHALL have F_imem_rdata  in  32  read data; valid only when F_imem_valid=1.
REQ-008 SHALL have F_imem_valid  in  1  one-cycle response strobe, at least 1 cycle after request rises.
REQ-009 SHALL have F_PC  out  32  PC of the fetched or in-flight instruction.
REQ-010 SHALL have F_instr  out  32  buffered instruction for the F/D register.
REQ-011 SHALL have F_valid  out  1  F_instr/F_PC are consumable by the F/D register.
REQ-012 SHALL have F_excAdEL  out  1  fetch address error on the held instruction.

Function
REQ-013 SHALL implement FSM states REQ, HOLD.
REQ-014 In REQ with aligned, in-range F_PC: F_imem_req=1; F_imem_addr held constant until F_imem_valid.
REQ-015 REQ and F_imem_valid=1: buffer <= F_imem_rdata; F_excAdEL <= 0; next state HOLD.
REQ-016 REQ with F_PC[1:0]!=0 or F_PC outside 0x0000_3000..0x0000_6FFC: F_imem_req=0; buffer <= 0x0000_0000 (nop); F_excAdEL <= 1; next state HOLD after 1 cycle.
REQ-017 HOLD: F_valid=1, F_imem_req=0; F_instr = buffer.
REQ-018 HOLD and stall=0 (advance): F_PC <= D_npc; next state REQ; F_excAdEL <= 0.
REQ-019 HOLD and stall=1: all state held; D_npc ignored.
REQ-020 REQ: F_valid=0; stall has no effect in REQ.
REQ-021 F_imem_valid SHALL be ignored in HOLD; it never occurs legally there.
REQ-022 Minimum throughput SHALL be one instruction per 2 cycles (1-cycle memory latency, no stall).
REQ-023 F_PC SHALL change only on advance or reset; D_npc is not width-checked, all 32 bits are taken.

Reset
REQ-024 On reset: F_PC=0x0000_3000, state REQ, buffer=0, F_valid=0, F_excAdEL=0, F_imem_req=0 while reset is high.
REQ-025 Reset mid-request SHALL abandon the request; instruction memory shares reset, so no stale F_imem_valid arrives afterwards.
REQ-026 After reset falls, the first request SHALL be issued at 0x0000_3000 in the first cycle.

Structure
REQ-027 PC_RESET (0x0000_3000), IM_BASE, IM_TOP (0x0000_6FFC), and NOP (0) SHALL live in the shared CPU constants package.
REQ-028 FSM state encoding SHALL be a package-level 1-bit enum.
REQ-029 No sub-module is required; the PC register and range checker stay inline.

Verification
REQ-030 Reset release, memory latency 1, stall=0, D_npc=F_PC+4 -> requests at 0x3000, 0x3004, 0x3008; F_valid high every second cycle; F_instr matches memory.
REQ-031 HOLD with stall=1 for 3 cycles, D_npc changing -> F_PC/F_instr frozen; on stall drop, F_PC = D_npc of that cycle.
REQ-032 Memory latency 4 -> F_imem_addr stable for 4 cycles, F_valid=0 throughout, then HOLD with the correct instruction.
REQ-033 D_npc=0x0000_3002 on advance -> no request, F_instr=0, F_excAdEL=1, F_valid=1 next cycle; same for D_npc=0x0000_7000.
REQ-034 Assert reset while a request is outstanding at 0x3010 -> F_imem_req=0 immediately; after release, request at 0x3000.
REQ-035 Branch case, D_npc=0x0000_3100 on advance -> next F_imem_addr=0x3100.
